digit_scroller: RTL

Upstream frame source for the 4-digit multiplexed seven-segment driver. It stores a digit string of up to 16 BCD digits, loaded one digit per cycle. On a programmable tick it emits a 4-digit window of active-low segment patterns (seg0 = leftmost digit). The window either scrolls by one digit or pages by four. The display driver consumes seg0..seg3 as its per-digit pattern registers.

---
 rtl/digit_scroller.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/digit_scroller.sv
// rtl/digit_scroller.sv - 16-digit BCD buffer emitting scrolled or paged 4-digit seven-segment frames
module digit_scroller #(
    parameter int TICK_DIV = 25000000,
    parameter int MAX_LEN  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       wr_en,
    input  logic [3:0] wr_data,
    input  logic       run,
    input  logic       mode,
    output logic [6:0] seg0,
    output logic [6:0] seg1,
    output logic [6:0] seg2,
    output logic [6:0] seg3,
    output logic       frame_strobe,
    output logic [4:0] len,
    output logic       overflow
);

    localparam int             CW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [4:0]     FULL      = 5'(MAX_LEN);
    localparam logic [6:0]     BLANK     = 7'b1111111;

    logic [3:0]    digits [16];
    logic [3:0]    pos;
    logic [CW-1:0] count;
    logic          mode_q;
    logic          mode_chg;
    logic          tick;
    logic [6:0]    win [4];
    logic [3:0]    next_pos;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = BLANK;
        endcase
    endfunction

    // Three conditional subtracts cover len=1 (index up to pos+3 with pos=0).
    function automatic logic [3:0] wrap_idx(input logic [4:0] idx, input logic [4:0] n);
        logic [4:0] r;
        r = idx;
        for (int k = 0; k < 3; k++) begin
            if (r >= n) r = r - n;
        end
        return r[3:0];
    endfunction

    assign mode_chg = (mode != mode_q);
    assign tick     = run && !mode_chg && (count == TICK_LAST);

    always_comb begin
        logic [4:0] idx;
        for (int i = 0; i < 4; i++) begin
            idx = {1'b0, pos} + 5'(i);
            if (len == 5'd0) begin
                win[i] = BLANK;
            end else if (mode_q) begin
                win[i] = (idx < len) ? seg_code(digits[idx[3:0]]) : BLANK;
            end else begin
                win[i] = seg_code(digits[wrap_idx(idx, len)]);
            end
        end
    end

    always_comb begin
        next_pos = 4'd0;
        if (len != 5'd0) begin
            if (mode_q) begin
                if (({1'b0, pos} + 5'd4) < len) next_pos = pos + 4'd4;
            end else begin
                if (({1'b0, pos} + 5'd1) < len) next_pos = pos + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg0         <= BLANK;
            seg1         <= BLANK;
            seg2         <= BLANK;
            seg3         <= BLANK;
            frame_strobe <= 1'b0;
            len          <= 5'd0;
            overflow     <= 1'b0;
            pos          <= 4'd0;
            count        <= '0;
            mode_q       <= mode;
        end else begin
            mode_q       <= mode;
            frame_strobe <= tick;

            if (mode_chg) begin
                count <= '0;
            end else if (run) begin
                count <= (count == TICK_LAST) ? '0 : count + 1'b1;
            end

            if (tick) begin
                seg0 <= win[0];
                seg1 <= win[1];
                seg2 <= win[2];
                seg3 <= win[3];
            end

            // clear takes priority over both the write and any pos advance
            if (clear) begin
                len      <= 5'd0;
                pos      <= 4'd0;
                overflow <= 1'b0;
            end else begin
                if (mode_chg) begin
                    pos <= 4'd0;
                end else if (tick) begin
                    pos <= next_pos;
                end
                if (wr_en) begin
                    if (len == FULL) begin
                        overflow <= 1'b1;
                    end else begin
                        digits[len[3:0]] <= wr_data;
                        len              <= len + 5'd1;
                    end
                end
            end
        end
    end

endmodule
